// File: rtl/iceboard_regs_pkg.sv
// rtl/iceboard_regs_pkg.sv - register codes, constants and reset values for the iCEboard register bank
//
// Purpose: shared definitions for iceboard_regbank_v2 and its helpers.
// Contents: register code localparams, ID/bad-access constants, per-motor
//           configuration record with its reset value, byte-lane merge helper.

package iceboard_regs_pkg;

    // Register codes, address[15:8]
    localparam logic [7:0] REG_ID        = 8'h00;
    localparam logic [7:0] REG_KP        = 8'h01;
    localparam logic [7:0] REG_KI        = 8'h02;
    localparam logic [7:0] REG_KD        = 8'h03;
    localparam logic [7:0] REG_POSITION  = 8'h04;
    localparam logic [7:0] REG_PWM_LIMIT = 8'h08;
    localparam logic [7:0] REG_CTRL_MODE = 8'h0B;
    localparam logic [7:0] REG_SETPOINT  = 8'h0C;
    localparam logic [7:0] REG_STATUS    = 8'h0D;
    localparam logic [7:0] REG_CURRENT   = 8'h19;
    localparam logic [7:0] REG_COMMIT    = 8'h20;
    localparam logic [7:0] REG_CONFIG    = 8'h21;
    localparam logic [7:0] REG_AGE       = 8'h22;

    localparam logic [31:0] ID_VALUE  = 32'h1CEB0A2D;
    localparam logic [31:0] BAD_VALUE = 32'hDEADBEEF;

    localparam logic [15:0] KP_RST        = 16'd1;
    localparam logic [15:0] KI_RST        = 16'd0;
    localparam logic [15:0] KD_RST        = 16'd0;
    localparam logic [23:0] SETPOINT_RST  = 24'd0;
    localparam logic [23:0] PWM_LIMIT_RST = 24'd8388607;
    localparam logic [7:0]  CTRL_MODE_RST = 8'd3;

    // One motor's complete configuration; shadow and active copies share it
    // so a commit is a single record copy.
    typedef struct packed {
        logic [15:0] kp;
        logic [15:0] ki;
        logic [15:0] kd;
        logic [23:0] setpoint;
        logic [23:0] pwm_limit;
        logic [7:0]  ctrl_mode;
    } motor_cfg_t;

    localparam motor_cfg_t MOTOR_CFG_RST = '{
        kp:        KP_RST,
        ki:        KI_RST,
        kd:        KD_RST,
        setpoint:  SETPOINT_RST,
        pwm_limit: PWM_LIMIT_RST,
        ctrl_mode: CTRL_MODE_RST
    };

    // Replace the byte lanes of old_val selected by be with those of new_val.
    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  be
    );
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/stale_watchdog.sv
// rtl/stale_watchdog.sv - per-motor saturating age counter with sticky stale flag
//
// Purpose: counts cycles since the last status update of one motor.
// Ports:
//   clk, reset  single clock, synchronous active-high reset
//   kick        status update seen this cycle; clears age and stale
//   age         cycles since last kick/reset, saturating at 2^AGE_W-1
//   stale       set when age reaches STALE_TIMEOUT_CYCLES, held until kick

module stale_watchdog #(
    parameter int AGE_W                = 24,
    parameter int STALE_TIMEOUT_CYCLES = 5_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             kick,
    output logic [AGE_W-1:0] age,
    output logic             stale
);

    localparam logic [AGE_W-1:0] AGE_MAX = '1;
    localparam logic [AGE_W-1:0] TIMEOUT = AGE_W'(STALE_TIMEOUT_CYCLES);

    logic [AGE_W-1:0] w_age_next;

    assign w_age_next = (age == AGE_MAX) ? age : age + 1'b1;

    // stale is evaluated on the next age value so that it rises in the same
    // cycle the counter shows TIMEOUT.
    always_ff @(posedge clk) begin
        if (reset || kick) begin
            age   <= '0;
            stale <= 1'b0;
        end else begin
            age <= w_age_next;
            if (w_age_next >= TIMEOUT) begin
                stale <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/iceboard_regbank_v2.sv
// rtl/iceboard_regbank_v2.sv - Avalon-MM shadow/active register bank for iCEboard motors
//
// Purpose: HPS-side register bank; shadow writes reach the active outputs
//          atomically on a masked commit or in auto-commit mode; captures
//          per-motor status and flags motors whose status stops arriving.
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   address/write/read/...     Avalon-MM slave, [15:8] register, [7:0] motor
//   readdata, waitrequest      read data (registered), read stall
//   status_*                   status strobe and payload from comms
//   kp_o..control_mode_o       active configuration, motor i in slice i
//   commit_pulse_o             one-cycle pulse per motor whose active set changed

module iceboard_regbank_v2
    import iceboard_regs_pkg::*;
#(
    parameter int NUMBER_OF_MOTORS     = 8,
    parameter int STALE_TIMEOUT_CYCLES = 5_000_000,
    parameter int AGE_W                = 24
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [15:0]                    address,
    input  logic                           write,
    input  logic                           read,
    input  logic [31:0]                    writedata,
    input  logic [3:0]                     byteenable,
    output logic [31:0]                    readdata,
    output logic                           waitrequest,
    input  logic                           status_valid,
    input  logic [7:0]                     status_motor,
    input  logic [23:0]                    status_position,
    input  logic [12:0]                    status_current,
    input  logic [30:0]                    status_error,
    output logic [16*NUMBER_OF_MOTORS-1:0] kp_o,
    output logic [16*NUMBER_OF_MOTORS-1:0] ki_o,
    output logic [16*NUMBER_OF_MOTORS-1:0] kd_o,
    output logic [24*NUMBER_OF_MOTORS-1:0] setpoint_o,
    output logic [24*NUMBER_OF_MOTORS-1:0] pwm_limit_o,
    output logic [8*NUMBER_OF_MOTORS-1:0]  control_mode_o,
    output logic [NUMBER_OF_MOTORS-1:0]    commit_pulse_o
);

    localparam int IDX_W = (NUMBER_OF_MOTORS > 1) ? $clog2(NUMBER_OF_MOTORS) : 1;

    motor_cfg_t r_shadow [NUMBER_OF_MOTORS];
    motor_cfg_t r_active [NUMBER_OF_MOTORS];
    logic       r_auto_commit;
    logic       r_rd_phase;

    logic [23:0] r_position [NUMBER_OF_MOTORS];
    logic [12:0] r_current  [NUMBER_OF_MOTORS];
    logic [30:0] r_error    [NUMBER_OF_MOTORS];

    logic [AGE_W-1:0]            w_age [NUMBER_OF_MOTORS];
    logic [NUMBER_OF_MOTORS-1:0] w_stale;
    logic [NUMBER_OF_MOTORS-1:0] w_kick;

    logic [7:0]       w_reg;
    logic [7:0]       w_motor;
    logic             w_motor_ok;
    logic [IDX_W-1:0] w_idx;
    logic             w_wr;
    logic             w_shadow_wr;
    logic             w_commit_wr;
    logic             w_config_wr;
    logic             w_is_shadow_reg;
    motor_cfg_t       w_cur_cfg;
    motor_cfg_t       w_merged_cfg;
    logic [31:0]      w_old_field;
    logic [31:0]      w_new_field;
    logic [31:0]      w_rd_value;

    // ---------------------------------------------------------------- decode
    assign w_reg      = address[15:8];
    assign w_motor    = address[7:0];
    assign w_motor_ok = ({24'd0, w_motor} < 32'(NUMBER_OF_MOTORS));
    // Out-of-range motors fold onto index 0; every use is qualified by w_motor_ok.
    assign w_idx      = w_motor_ok ? w_motor[IDX_W-1:0] : '0;

    // A read in the same cycle wins; the write is dropped.
    assign w_wr        = write & ~read;
    assign w_shadow_wr = w_wr & w_motor_ok & w_is_shadow_reg;
    assign w_commit_wr = w_wr & (w_reg == REG_COMMIT);
    assign w_config_wr = w_wr & (w_reg == REG_CONFIG);

    // Build the addressed motor's shadow record with the written field merged
    // lane by lane; truncation into the field discards lanes above its width.
    always_comb begin
        w_cur_cfg       = r_shadow[w_idx];
        w_old_field     = 32'd0;
        w_is_shadow_reg = 1'b0;
        case (w_reg)
            REG_KP:        begin w_old_field = {16'd0, w_cur_cfg.kp};        w_is_shadow_reg = 1'b1; end
            REG_KI:        begin w_old_field = {16'd0, w_cur_cfg.ki};        w_is_shadow_reg = 1'b1; end
            REG_KD:        begin w_old_field = {16'd0, w_cur_cfg.kd};        w_is_shadow_reg = 1'b1; end
            REG_SETPOINT:  begin w_old_field = {8'd0,  w_cur_cfg.setpoint};  w_is_shadow_reg = 1'b1; end
            REG_PWM_LIMIT: begin w_old_field = {8'd0,  w_cur_cfg.pwm_limit}; w_is_shadow_reg = 1'b1; end
            REG_CTRL_MODE: begin w_old_field = {24'd0, w_cur_cfg.ctrl_mode}; w_is_shadow_reg = 1'b1; end
            default:       begin w_old_field = 32'd0;                        w_is_shadow_reg = 1'b0; end
        endcase
        w_new_field  = merge_lanes(w_old_field, writedata, byteenable);
        w_merged_cfg = w_cur_cfg;
        case (w_reg)
            REG_KP:        w_merged_cfg.kp        = w_new_field[15:0];
            REG_KI:        w_merged_cfg.ki        = w_new_field[15:0];
            REG_KD:        w_merged_cfg.kd        = w_new_field[15:0];
            REG_SETPOINT:  w_merged_cfg.setpoint  = w_new_field[23:0];
            REG_PWM_LIMIT: w_merged_cfg.pwm_limit = w_new_field[23:0];
            REG_CTRL_MODE: w_merged_cfg.ctrl_mode = w_new_field[7:0];
            default:       w_merged_cfg           = w_cur_cfg;
        endcase
    end

    // ------------------------------------------------- shadow / active store
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUMBER_OF_MOTORS; i++) begin
                r_shadow[i] <= MOTOR_CFG_RST;
                r_active[i] <= MOTOR_CFG_RST;
            end
            r_auto_commit  <= 1'b0;
            commit_pulse_o <= '0;
        end else begin
            commit_pulse_o <= '0;
            if (w_config_wr) begin
                r_auto_commit <= writedata[0];
            end
            for (int i = 0; i < NUMBER_OF_MOTORS; i++) begin
                if (w_shadow_wr && (w_idx == IDX_W'(i))) begin
                    r_shadow[i] <= w_merged_cfg;
                    // Auto-commit pushes the merged record, not the stale shadow.
                    if (r_auto_commit) begin
                        r_active[i]       <= w_merged_cfg;
                        commit_pulse_o[i] <= 1'b1;
                    end
                end
                if (w_commit_wr && writedata[i]) begin
                    r_active[i]       <= r_shadow[i];
                    commit_pulse_o[i] <= 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------- status capture
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUMBER_OF_MOTORS; i++) begin
                r_position[i] <= '0;
                r_current[i]  <= '0;
                r_error[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUMBER_OF_MOTORS; i++) begin
                if (w_kick[i]) begin
                    r_position[i] <= status_position;
                    r_current[i]  <= status_current;
                    r_error[i]    <= status_error;
                end
            end
        end
    end

    // ------------------------------------------------------------- read path
    always_comb begin
        w_rd_value = BAD_VALUE;
        case (w_reg)
            REG_COMMIT: w_rd_value = 32'd0;
            REG_CONFIG: w_rd_value = {31'd0, r_auto_commit};
            default: begin
                if (w_motor_ok) begin
                    case (w_reg)
                        REG_ID:        w_rd_value = ID_VALUE;
                        REG_KP:        w_rd_value = {{16{w_cur_cfg.kp[15]}}, w_cur_cfg.kp};
                        REG_KI:        w_rd_value = {{16{w_cur_cfg.ki[15]}}, w_cur_cfg.ki};
                        REG_KD:        w_rd_value = {{16{w_cur_cfg.kd[15]}}, w_cur_cfg.kd};
                        REG_SETPOINT:  w_rd_value = {{8{w_cur_cfg.setpoint[23]}}, w_cur_cfg.setpoint};
                        REG_PWM_LIMIT: w_rd_value = {8'd0, w_cur_cfg.pwm_limit};
                        REG_CTRL_MODE: w_rd_value = {24'd0, w_cur_cfg.ctrl_mode};
                        REG_POSITION:  w_rd_value = {{8{r_position[w_idx][23]}}, r_position[w_idx]};
                        REG_CURRENT:   w_rd_value = {{19{r_current[w_idx][12]}}, r_current[w_idx]};
                        REG_STATUS:    w_rd_value = {w_stale[w_idx], r_error[w_idx]};
                        REG_AGE:       w_rd_value = 32'(w_age[w_idx]);
                        default:       w_rd_value = BAD_VALUE;
                    endcase
                end
            end
        endcase
    end

    // First read cycle stalls and registers the data; the second presents it.
    // Capturing in the first cycle is what makes a coincident status strobe
    // invisible to the read.
    assign waitrequest = read & ~r_rd_phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_phase <= 1'b0;
            readdata   <= 32'd0;
        end else if (read && !r_rd_phase) begin
            r_rd_phase <= 1'b1;
            readdata   <= w_rd_value;
        end else begin
            r_rd_phase <= 1'b0;
        end
    end

    // ------------------------------------------------ per-motor watchdog/out
    for (genvar g = 0; g < NUMBER_OF_MOTORS; g++) begin : g_motor
        assign w_kick[g] = status_valid && (status_motor == 8'(g));

        stale_watchdog #(
            .AGE_W                (AGE_W),
            .STALE_TIMEOUT_CYCLES (STALE_TIMEOUT_CYCLES)
        ) u_watchdog (
            .clk   (clk),
            .reset (reset),
            .kick  (w_kick[g]),
            .age   (w_age[g]),
            .stale (w_stale[g])
        );

        assign kp_o[16*g +: 16]          = r_active[g].kp;
        assign ki_o[16*g +: 16]          = r_active[g].ki;
        assign kd_o[16*g +: 16]          = r_active[g].kd;
        assign setpoint_o[24*g +: 24]    = r_active[g].setpoint;
        assign pwm_limit_o[24*g +: 24]   = r_active[g].pwm_limit;
        assign control_mode_o[8*g +: 8]  = r_active[g].ctrl_mode;
    end

endmodule

// File: tb/tb_iceboard_regbank_v2.sv
// tb/tb_iceboard_regbank_v2.sv - scoreboard bench for iceboard_regbank_v2 with a reference model

module tb_iceboard_regbank_v2;

    localparam int N       = 8;
    localparam int TMO     = 10;
    localparam int AW      = 6;
    localparam int AGE_MAX = 63;

    logic           clk;
    logic           reset;
    logic [15:0]    address;
    logic           write;
    logic           read;
    logic [31:0]    writedata;
    logic [3:0]     byteenable;
    logic [31:0]    readdata;
    logic           waitrequest;
    logic           status_valid;
    logic [7:0]     status_motor;
    logic [23:0]    status_position;
    logic [12:0]    status_current;
    logic [30:0]    status_error;
    logic [16*N-1:0] kp_o, ki_o, kd_o;
    logic [24*N-1:0] setpoint_o, pwm_limit_o;
    logic [8*N-1:0]  control_mode_o;
    logic [N-1:0]    commit_pulse_o;

    iceboard_regbank_v2 #(
        .NUMBER_OF_MOTORS     (N),
        .STALE_TIMEOUT_CYCLES (TMO),
        .AGE_W                (AW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .address         (address),
        .write           (write),
        .read            (read),
        .writedata       (writedata),
        .byteenable      (byteenable),
        .readdata        (readdata),
        .waitrequest     (waitrequest),
        .status_valid    (status_valid),
        .status_motor    (status_motor),
        .status_position (status_position),
        .status_current  (status_current),
        .status_error    (status_error),
        .kp_o            (kp_o),
        .ki_o            (ki_o),
        .kd_o            (kd_o),
        .setpoint_o      (setpoint_o),
        .pwm_limit_o     (pwm_limit_o),
        .control_mode_o  (control_mode_o),
        .commit_pulse_o  (commit_pulse_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];
    bit status_rand_en = 1'b0;
    bit model_live     = 1'b0;

    // Reference model: fields 0..5 = kp, ki, kd, setpoint, pwm_limit, mode
    logic [31:0] sh  [6][N];
    logic [31:0] act [6][N];
    logic [31:0] m_pos [N];
    logic [31:0] m_cur [N];
    logic [31:0] m_err [N];
    int          m_age [N];
    logic        m_auto;
    logic [N-1:0] m_pulse;

    function automatic int field_w(input int f);
        if (f <= 2) return 16;
        if (f <= 4) return 24;
        return 8;
    endfunction

    function automatic int field_of(input logic [7:0] r);
        case (r)
            8'h01: return 0;
            8'h02: return 1;
            8'h03: return 2;
            8'h0C: return 3;
            8'h08: return 4;
            8'h0B: return 5;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] rst_val(input int f);
        if (f == 0) return 32'd1;
        if (f == 4) return 32'd8388607;
        if (f == 5) return 32'd3;
        return 32'd0;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] v, input int w, input bit sgn);
        logic [31:0] mask;
        mask = (32'h1 << w) - 32'h1;
        if (sgn && v[w-1]) return v | ~mask;
        return v & mask;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be, input int w);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b] && (b * 8 < w)) res[b*8 +: 8] = wd[b*8 +: 8];
        end
        return res & ((32'h1 << w) - 32'h1);
    endfunction

    function automatic logic [31:0] model_read(input logic [15:0] a);
        logic [7:0] r;
        int mi, f;
        r  = a[15:8];
        mi = int'(a[7:0]);
        f  = field_of(r);
        if (r == 8'h20) return 32'd0;
        if (r == 8'h21) return {31'd0, m_auto};
        if (mi >= N) return 32'hDEADBEEF;
        if (f >= 0) return extend(sh[f][mi], field_w(f), f <= 3);
        case (r)
            8'h00: return 32'h1CEB0A2D;
            8'h04: return extend(m_pos[mi], 24, 1'b1);
            8'h19: return extend(m_cur[mi], 13, 1'b1);
            8'h0D: return {(m_age[mi] >= TMO), m_err[mi][30:0]};
            8'h22: return 32'(m_age[mi]);
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    // Applies the behaviour of one clock edge using the inputs held across it.
    task automatic model_edge();
        int mi, f;
        if (reset) begin
            for (int m = 0; m < N; m++) begin
                for (int k = 0; k < 6; k++) begin
                    sh[k][m]  = rst_val(k);
                    act[k][m] = rst_val(k);
                end
                m_pos[m] = 0; m_cur[m] = 0; m_err[m] = 0; m_age[m] = 0;
            end
            m_auto     = 1'b0;
            m_pulse    = '0;
            model_live = 1'b1;
        end else begin
            m_pulse = '0;
            if (write && !read) begin
                mi = int'(address[7:0]);
                f  = field_of(address[15:8]);
                if (address[15:8] == 8'h20) begin
                    for (int m = 0; m < N; m++) begin
                        if (writedata[m]) begin
                            for (int k = 0; k < 6; k++) act[k][m] = sh[k][m];
                            m_pulse[m] = 1'b1;
                        end
                    end
                end else if (address[15:8] == 8'h21) begin
                    m_auto = writedata[0];
                end else if (f >= 0 && mi < N) begin
                    sh[f][mi] = merge(sh[f][mi], writedata, byteenable, field_w(f));
                    if (m_auto) begin
                        for (int k = 0; k < 6; k++) act[k][mi] = sh[k][mi];
                        m_pulse[mi] = 1'b1;
                    end
                end
            end
            for (int m = 0; m < N; m++) begin
                if (status_valid && int'(status_motor) == m) begin
                    m_pos[m] = {8'd0, status_position};
                    m_cur[m] = {19'd0, status_current};
                    m_err[m] = {1'b0, status_error};
                    m_age[m] = 0;
                end else if (m_age[m] < AGE_MAX) begin
                    m_age[m] = m_age[m] + 1;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive_status();
        if (status_rand_en && $urandom_range(0, 3) == 0) begin
            status_valid    = 1'b1;
            status_motor    = 8'($urandom_range(0, 9));
            status_position = 24'($urandom);
            status_current  = 13'($urandom);
            status_error    = 31'($urandom);
        end else begin
            status_valid = 1'b0;
        end
    endtask

    task automatic op(input bit w, input bit r, input logic [15:0] a,
                      input logic [31:0] d, input logic [3:0] be);
        int waits;
        address    = a;
        write      = w;
        read       = r;
        writedata  = d;
        byteenable = be;
        drive_status();
        if (r) begin
            exp_q.push_back(model_read(a));
            #1;
            waits = 0;
            while (waitrequest && waits < 4) begin
                tick();
                drive_status();
                waits++;
            end
            chk("read_wait_cycles", 256'(waits), 256'(1));
            tick();
        end else begin
            tick();
        end
        write        = 1'b0;
        read         = 1'b0;
        status_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            drive_status();
            tick();
        end
        status_valid = 1'b0;
    endtask

    // Monitor: compares active outputs every cycle and pops the scoreboard
    // whenever the DUT presents read data.
    initial begin
        logic [16*N-1:0] e_kp, e_ki, e_kd;
        logic [24*N-1:0] e_sp, e_pl;
        logic [8*N-1:0]  e_cm;
        logic [31:0]     e_rd;
        forever begin
            @(negedge clk);
            if (model_live) begin
                for (int m = 0; m < N; m++) begin
                    e_kp[16*m +: 16] = act[0][m][15:0];
                    e_ki[16*m +: 16] = act[1][m][15:0];
                    e_kd[16*m +: 16] = act[2][m][15:0];
                    e_sp[24*m +: 24] = act[3][m][23:0];
                    e_pl[24*m +: 24] = act[4][m][23:0];
                    e_cm[8*m +: 8]   = act[5][m][7:0];
                end
                chk("kp_o", 256'(kp_o), 256'(e_kp));
                chk("ki_o", 256'(ki_o), 256'(e_ki));
                chk("kd_o", 256'(kd_o), 256'(e_kd));
                chk("setpoint_o", 256'(setpoint_o), 256'(e_sp));
                chk("pwm_limit_o", 256'(pwm_limit_o), 256'(e_pl));
                chk("control_mode_o", 256'(control_mode_o), 256'(e_cm));
                chk("commit_pulse_o", 256'(commit_pulse_o), 256'(m_pulse));
                if (!reset && read && !waitrequest) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL readdata_unexpected: got %h with no read pending", readdata);
                    end else begin
                        e_rd = exp_q.pop_front();
                        chk("readdata", 256'(readdata), 256'(e_rd));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

    logic [7:0] codes [15];

    initial begin
        codes = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h08, 8'h0B, 8'h0C,
                  8'h0D, 8'h19, 8'h20, 8'h21, 8'h22, 8'h05, 8'hFF};
        reset = 1'b1; address = '0; write = 1'b0; read = 1'b0;
        writedata = '0; byteenable = '0; status_valid = 1'b0;
        status_motor = '0; status_position = '0; status_current = '0; status_error = '0;
        repeat (3) tick();
        reset = 1'b0;
        chk("reset_readdata", 256'(readdata), 256'(0));
        chk("reset_waitrequest", 256'(waitrequest), 256'(0));

        op(1'b0, 1'b1, 16'h0000, 32'd0, 4'h0);
        op(1'b0, 1'b1, 16'h0103, 32'd0, 4'h0);

        op(1'b1, 1'b0, 16'h0102, 32'h0000_1234, 4'hF);
        op(1'b0, 1'b1, 16'h0102, 32'd0, 4'h0);
        op(1'b1, 1'b0, 16'h2000, 32'h0000_0004, 4'hF);
        idle(2);

        op(1'b1, 1'b0, 16'h2100, 32'd1, 4'hF);
        op(1'b1, 1'b0, 16'h0C05, 32'hFFFF_FF9C, 4'hF);
        op(1'b1, 1'b0, 16'h0C05, 32'h0000_007F, 4'h1);
        op(1'b0, 1'b1, 16'h0C05, 32'd0, 4'h0);
        op(1'b0, 1'b1, 16'h2100, 32'd0, 4'h0);

        op(1'b0, 1'b1, 16'h0D01, 32'd0, 4'h0);
        status_valid = 1'b1; status_motor = 8'd1; status_error = 31'h5;
        status_position = 24'hFFF000; status_current = 13'h1F00;
        tick();
        status_valid = 1'b0;
        op(1'b0, 1'b1, 16'h0D01, 32'd0, 4'h0);
        op(1'b0, 1'b1, 16'h0401, 32'd0, 4'h0);
        op(1'b0, 1'b1, 16'h1901, 32'd0, 4'h0);
        op(1'b0, 1'b1, 16'h2201, 32'd0, 4'h0);
        idle(12);
        op(1'b0, 1'b1, 16'h0D01, 32'd0, 4'h0);

        op(1'b0, 1'b1, 16'h0C09, 32'd0, 4'h0);
        op(1'b1, 1'b0, 16'h0109, 32'h0000_FFFF, 4'hF);
        op(1'b1, 1'b0, 16'h2000, 32'hFFFF_FFFF, 4'hF);
        idle(70);
        op(1'b0, 1'b1, 16'h2200, 32'd0, 4'h0);
        op(1'b0, 1'b1, 16'h0D00, 32'd0, 4'h0);
        op(1'b1, 1'b1, 16'h0101, 32'h0000_5555, 4'hF);

        status_rand_en = 1'b1;
        repeat (400) begin
            logic [7:0]  c;
            logic [7:0]  m;
            int          kind;
            c    = codes[$urandom_range(0, 14)];
            m    = 8'($urandom_range(0, 9));
            kind = $urandom_range(0, 9);
            if (kind < 4)
                op(1'b1, 1'b0, {c, m}, $urandom, 4'($urandom));
            else if (kind < 9)
                op(1'b0, 1'b1, {c, m}, 32'd0, 4'h0);
            else
                op(1'b1, 1'b1, {c, m}, $urandom, 4'($urandom));
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 5));
        end
        status_rand_en = 1'b0;

        address = 16'h0000; read = 1'b1;
        #1;
        chk("abort_first_wait", 256'(waitrequest), 256'(1));
        tick();
        reset = 1'b1; read = 1'b0;
        tick();
        reset = 1'b0;
        chk("abort_readdata", 256'(readdata), 256'(0));
        chk("abort_waitrequest", 256'(waitrequest), 256'(0));
        op(1'b0, 1'b1, 16'h0103, 32'd0, 4'h0);
        op(1'b0, 1'b1, 16'h2100, 32'd0, 4'h0);

        idle(3);
        chk("scoreboard_drained", 256'(exp_q.size()), 256'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
